// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - per-cycle arbiter sharing one instruction memory port between fetch and loader
// Tracks in-flight reads in a MEM_LAT-deep {valid, owner} pipe so each response returns to its issuer.
module imem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LAT     = 1,
  parameter int LOADER_PRIO = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  localparam int CW = 4;

  logic [CW-1:0]      starve_q, starve_d;
  logic               rr_fetch_q, rr_fetch_d;
  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [MEM_LAT-1:0] own_q, own_d;
  logic               fetch_wins;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      rr_fetch_q <= 1'b1;
      vld_q      <= '0;
      own_q      <= '0;
    end else begin
      starve_q   <= starve_d;
      rr_fetch_q <= rr_fetch_d;
      vld_q      <= vld_d;
      own_q      <= own_d;
    end
  end

  always_comb begin
    fetch_wins = f_req;
    if (f_req && l_req) begin
      if (LOADER_PRIO != 0) fetch_wins = (starve_q == CW'(STARVE_MAX));
      else                  fetch_wins = rr_fetch_q;
    end

    f_gnt   = ~rst & f_req & fetch_wins;
    l_gnt   = ~rst & l_req & ~fetch_wins;
    m_req   = f_gnt | l_gnt;
    m_we    = l_gnt & l_we;
    m_addr  = f_gnt ? f_addr : (l_gnt ? l_addr : '0);
    m_wdata = l_gnt ? l_wdata : '0;

    starve_d = '0;
    if (f_req && !f_gnt)
      starve_d = (starve_q == CW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;

    // Pointer only moves when someone is actually granted.
    rr_fetch_d = rr_fetch_q;
    if (f_gnt)      rr_fetch_d = 1'b0;
    else if (l_gnt) rr_fetch_d = 1'b1;

    vld_d    = '0;
    own_d    = '0;
    vld_d[0] = m_req & ~m_we;
    own_d[0] = l_gnt;
    for (int i = 1; i < MEM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end

    f_rvalid = vld_q[MEM_LAT-1] & ~own_q[MEM_LAT-1];
    l_rvalid = vld_q[MEM_LAT-1] &  own_q[MEM_LAT-1];
    f_rdata  = f_rvalid ? m_rdata : '0;
    l_rdata  = l_rvalid ? m_rdata : '0;
    busy     = |vld_q;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - self-checking bench for imem_port_arbiter
// Lane 0: priority/STARVE_MAX=4, lane 1: round-robin, lane 2: priority/STARVE_MAX=2/MEM_LAT=3.
module tb_imem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, f_req, l_req, l_we, init_mem;
  logic [31:0] f_addr, l_addr, l_wdata;

  logic        fg[3], lg[3], frv[3], lrv[3], mreq[3], mwe[3], bsy[3];
  logic [31:0] frd[3], lrd[3], maddr[3], mwd[3], mrd[3];

  logic [31:0] pipe[3][4];
  logic [31:0] emem[3][256];

  int total = 0;
  int bad   = 0;

  function automatic int lat_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction
  function automatic bit prio_of(input int k);
    return (k != 1);
  endfunction
  function automatic int sm_of(input int k);
    return (k == 2) ? 2 : 4;
  endfunction
  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 + 32'(i);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_port_arbiter #(
      .AW(32), .DW(32),
      .MEM_LAT((g == 2) ? 3 : 1),
      .LOADER_PRIO((g == 1) ? 0 : 1),
      .STARVE_MAX((g == 2) ? 2 : 4)
    ) u_dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(fg[g]), .f_rvalid(frv[g]), .f_rdata(frd[g]),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(lg[g]), .l_rvalid(lrv[g]), .l_rdata(lrd[g]),
      .m_req(mreq[g]), .m_we(mwe[g]), .m_addr(maddr[g]), .m_wdata(mwd[g]),
      .m_rdata(mrd[g]), .busy(bsy[g])
    );
  end

  // Memory environment: one private memory per lane with its own read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      for (int s = 3; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
      pipe[k][0] <= (mreq[k] && !mwe[k]) ? emem[k][maddr[k][9:2]] : 32'h0;
      if (mreq[k] && mwe[k]) emem[k][maddr[k][9:2]] <= mwd[k];
      if (init_mem)
        for (int i = 0; i < 256; i++) emem[k][i] <= init_word(i);
    end
  end
  assign mrd[0] = pipe[0][0];
  assign mrd[1] = pipe[1][0];
  assign mrd[2] = pipe[2][2];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; f_req = 1'b1; l_req = 1'b1; f_addr = 32'h8; l_addr = 32'hC;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (fg[k] !== 1'b0) begin bad++; $display("FAIL reset_f_gnt lane%0d got=%b exp=0", k, fg[k]); end
      total++; if (lg[k] !== 1'b0) begin bad++; $display("FAIL reset_l_gnt lane%0d got=%b exp=0", k, lg[k]); end
      total++; if (mreq[k] !== 1'b0) begin bad++; $display("FAIL reset_m_req lane%0d got=%b exp=0", k, mreq[k]); end
      total++; if (maddr[k] !== 32'h0) begin bad++; $display("FAIL reset_m_addr lane%0d got=%h exp=0", k, maddr[k]); end
      total++; if ({frv[k], lrv[k], bsy[k]} !== 3'b000) begin bad++; $display("FAIL reset_rvalid_busy lane%0d got=%b exp=000", k, {frv[k], lrv[k], bsy[k]}); end
    end
  endtask

  task automatic test_fetch_only();
    logic ev;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      f_req = (i < 3); f_addr = 32'(4 * i); l_req = 1'b0;
      #1;
      ev = (i >= 1 && i <= 3);
      total++; if (fg[0] !== (i < 3)) begin bad++; $display("FAIL fetch_gnt cyc%0d got=%b exp=%b", i, fg[0], i < 3); end
      total++; if (frv[0] !== ev) begin bad++; $display("FAIL fetch_rvalid cyc%0d got=%b exp=%b", i, frv[0], ev); end
      total++; if (frd[0] !== (ev ? init_word(i - 1) : 32'h0)) begin bad++; $display("FAIL fetch_rdata cyc%0d got=%h exp=%h", i, frd[0], ev ? init_word(i - 1) : 32'h0); end
      total++; if (lrv[0] !== 1'b0) begin bad++; $display("FAIL fetch_l_rvalid cyc%0d got=%b exp=0", i, lrv[0]); end
    end
  endtask

  task automatic test_starvation_and_rr();
    bit e0, e1;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; f_addr = 32'h40; l_addr = 32'h80;
      #1;
      e0 = (i % 5 == 4);
      e1 = (i % 2 == 0);
      total++; if ({fg[0], lg[0]} !== {e0, ~e0}) begin bad++; $display("FAIL starve_gnt cyc%0d got=%b%b exp=%b%b", i, fg[0], lg[0], e0, ~e0); end
      total++; if ({fg[1], lg[1]} !== {e1, ~e1}) begin bad++; $display("FAIL rr_gnt cyc%0d got=%b%b exp=%b%b", i, fg[1], lg[1], e1, ~e1); end
    end
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_then_fetch();
    bit ev;
    do_reset();
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'h00500093;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if ({lg[k], mwe[k]} !== 2'b11) begin bad++; $display("FAIL wr_gnt_we lane%0d got=%b%b exp=11", k, lg[k], mwe[k]); end
      total++; if ({maddr[k], mwd[k]} !== {32'h10, 32'h00500093}) begin bad++; $display("FAIL wr_addr_data lane%0d got=%h/%h exp=10/00500093", k, maddr[k], mwd[k]); end
    end
    @(negedge clk);
    l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h10;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (fg[k] !== 1'b1) begin bad++; $display("FAIL raw_f_gnt lane%0d got=%b exp=1", k, fg[k]); end
    end
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      f_req = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
        ev = (c == 1 + lat_of(k));
        total++; if (frv[k] !== ev) begin bad++; $display("FAIL raw_rvalid lane%0d cyc%0d got=%b exp=%b", k, c, frv[k], ev); end
        total++; if (frd[k] !== (ev ? 32'h00500093 : 32'h0)) begin bad++; $display("FAIL raw_rdata lane%0d cyc%0d got=%h exp=%h", k, c, frd[k], ev ? 32'h00500093 : 32'h0); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    @(negedge clk);
    f_req = 1'b1; l_req = 1'b0; f_addr = 32'h20;
    @(negedge clk);
    f_addr = 32'h24;
    #1;
    total++; if (bsy[2] !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", bsy[2]); end
    @(negedge clk);
    f_req = 1'b0; rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (bsy[k] !== 1'b0) begin bad++; $display("FAIL midrst_busy_in_rst lane%0d got=%b exp=0", k, bsy[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        total++; if ({frv[k], lrv[k], bsy[k]} !== 3'b000) begin bad++; $display("FAIL midrst_after lane%0d cyc%0d got=%b exp=000", k, c, {frv[k], lrv[k], bsy[k]}); end
      end
      @(negedge clk);
    end
  endtask

  // Reference: per-lane scheduled-response table indexed by retire cycle, plus a model memory.
  task automatic test_random();
    bit          sv[3][8], so[3][8];
    logic [31:0] sd[3][8];
    logic [31:0] mmem[3][256];
    int          den[3];
    bit          rr_f[3];
    bit          ef, el, ev, eo, ebusy;
    logic [31:0] eaddr, ed;
    int          slot;
    for (int k = 0; k < 3; k++) begin
      den[k] = 0; rr_f[k] = 1'b1;
      for (int s = 0; s < 8; s++) begin sv[k][s] = 1'b0; so[k][s] = 1'b0; sd[k][s] = 32'h0; end
      for (int i = 0; i < 256; i++) mmem[k][i] = init_word(i);
      mmem[k][4] = 32'h00500093;
    end
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      f_req   = ($urandom_range(0, 3) != 0);
      l_req   = ($urandom_range(0, 1) != 0);
      l_we    = ($urandom_range(0, 2) == 0);
      f_addr  = 32'($urandom_range(0, 63));
      l_addr  = 32'($urandom_range(0, 63));
      l_wdata = $urandom;
      #1;
      slot = cyc % 8;
      for (int k = 0; k < 3; k++) begin
        if (f_req && l_req) ef = prio_of(k) ? (den[k] == sm_of(k)) : rr_f[k];
        else                ef = f_req;
        el    = l_req && !ef;
        eaddr = ef ? f_addr : (el ? l_addr : 32'h0);
        ev    = sv[k][slot];
        eo    = so[k][slot];
        ed    = sd[k][slot];
        ebusy = 1'b0;
        for (int s = 0; s < 8; s++) ebusy = ebusy | sv[k][s];
        total++; if ({fg[k], lg[k], mreq[k]} !== {ef, el, ef | el}) begin bad++; $display("FAIL rnd_gnt lane%0d cyc%0d got=%b%b%b exp=%b%b%b", k, cyc, fg[k], lg[k], mreq[k], ef, el, ef | el); end
        total++; if (mwe[k] !== (el && l_we)) begin bad++; $display("FAIL rnd_m_we lane%0d cyc%0d got=%b exp=%b", k, cyc, mwe[k], el && l_we); end
        total++; if (maddr[k] !== eaddr) begin bad++; $display("FAIL rnd_m_addr lane%0d cyc%0d got=%h exp=%h", k, cyc, maddr[k], eaddr); end
        total++; if (mwd[k] !== (el ? l_wdata : 32'h0)) begin bad++; $display("FAIL rnd_m_wdata lane%0d cyc%0d got=%h exp=%h", k, cyc, mwd[k], el ? l_wdata : 32'h0); end
        total++; if ({frv[k], lrv[k]} !== {ev && !eo, ev && eo}) begin bad++; $display("FAIL rnd_rvalid lane%0d cyc%0d got=%b%b exp=%b%b", k, cyc, frv[k], lrv[k], ev && !eo, ev && eo); end
        total++; if (frd[k] !== ((ev && !eo) ? ed : 32'h0)) begin bad++; $display("FAIL rnd_f_rdata lane%0d cyc%0d got=%h exp=%h", k, cyc, frd[k], (ev && !eo) ? ed : 32'h0); end
        total++; if (lrd[k] !== ((ev && eo) ? ed : 32'h0)) begin bad++; $display("FAIL rnd_l_rdata lane%0d cyc%0d got=%h exp=%h", k, cyc, lrd[k], (ev && eo) ? ed : 32'h0); end
        total++; if (bsy[k] !== ebusy) begin bad++; $display("FAIL rnd_busy lane%0d cyc%0d got=%b exp=%b", k, cyc, bsy[k], ebusy); end
        sv[k][slot] = 1'b0;
        if (ef || (el && !l_we)) begin
          sv[k][(cyc + lat_of(k)) % 8] = 1'b1;
          so[k][(cyc + lat_of(k)) % 8] = el;
          sd[k][(cyc + lat_of(k)) % 8] = mmem[k][eaddr[9:2]];
        end
        if (el && l_we) mmem[k][l_addr[9:2]] = l_wdata;
        den[k] = (f_req && !ef) ? ((den[k] + 1 > sm_of(k)) ? sm_of(k) : den[k] + 1) : 0;
        if (ef)      rr_f[k] = 1'b0;
        else if (el) rr_f[k] = 1'b1;
      end
    end
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
    f_addr = 32'h0; l_addr = 32'h0; l_wdata = 32'h0; init_mem = 1'b1;
    @(negedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    test_reset();
    test_fetch_only();
    test_starvation_and_rr();
    test_write_then_fetch();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
